// File: rtl/keys_debounce_repeat_module.sv
// Four-key debouncer with press strobe, auto-repeat strobes and a clean held level.
// Feeds option_keys of optional_pwm_module: one strobe per press or repeat interval.
`timescale 1ns/1ps
module keys_debounce_repeat_module #(
    parameter int TICK_CYCLES     = 50000,
    parameter int PRESS_MS        = 20,
    parameter int RELEASE_MS      = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] keys_in,
    output logic [3:0] key_pulse,
    output logic [3:0] key_level
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [10:0] PRESS_N = 11'(PRESS_MS);
    localparam logic [10:0] REL_N   = 11'(RELEASE_MS);
    localparam logic [10:0] DELAY_N = 11'(REPEAT_DELAY_MS);
    localparam logic [10:0] RATE_N  = 11'(REPEAT_RATE_MS);
    localparam bit REPEAT_EN = (REPEAT_DELAY_MS != 0);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    // Per-channel state is kept visible by name for external checkers.
    state_t      state   [4];
    logic [10:0] cnt     [4];
    logic [10:0] cnt_inc [4];
    logic [3:0]  rep_done;

    logic [PW-1:0] presc;
    logic          tick;
    logic [3:0]    sync1, sync2;
    logic [3:0]    p;

    // Shared free-running 1 ms prescaler; key activity never restarts it.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            presc <= '0;
        else if (tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    assign tick = (presc == PRESC_LAST);

    // Raw keys are asynchronous; idle level of the synchronizer is "released".
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= keys_in;
            sync2 <= sync1;
        end
    end

    assign p = ~sync2;

    always_comb begin
        for (int i = 0; i < 4; i++)
            cnt_inc[i] = cnt[i] + 11'd1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            rep_done  <= '0;
            key_pulse <= '0;
            key_level <= '0;
        end else begin
            key_pulse <= '0;
            for (int i = 0; i < 4; i++) begin
                case (state[i])
                    IDLE: begin
                        cnt[i] <= '0;
                        if (p[i])
                            state[i] <= PRESS_DB;
                    end
                    PRESS_DB: begin
                        if (!p[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (tick) begin
                            if (cnt_inc[i] == PRESS_N) begin
                                state[i]     <= HELD;
                                cnt[i]       <= '0;
                                rep_done[i]  <= 1'b0;
                                key_pulse[i] <= 1'b1;
                                key_level[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt_inc[i];
                            end
                        end
                    end
                    HELD: begin
                        if (!p[i]) begin
                            state[i] <= REL_DB;
                            cnt[i]   <= '0;
                        end else if (REPEAT_EN && tick && !key_pulse[i]) begin
                            // First repeat waits the long delay, later ones the short rate.
                            if (cnt_inc[i] == (rep_done[i] ? RATE_N : DELAY_N)) begin
                                cnt[i]       <= '0;
                                rep_done[i]  <= 1'b1;
                                key_pulse[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt_inc[i];
                            end
                        end
                    end
                    REL_DB: begin
                        if (p[i]) begin
                            // A release glitch restarts the repeat delay from scratch.
                            state[i]    <= HELD;
                            cnt[i]      <= '0;
                            rep_done[i] <= 1'b0;
                        end else if (tick) begin
                            if (cnt_inc[i] == REL_N) begin
                                state[i]     <= IDLE;
                                cnt[i]       <= '0;
                                key_level[i] <= 1'b0;
                            end else begin
                                cnt[i] <= cnt_inc[i];
                            end
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keys_debounce_repeat_module.sv
// Bench for keys_debounce_repeat_module: directed windows, a segment table and
// random key activity, all checked cycle by cycle against a timestamp-based model.
`timescale 1ns/1ps
module tb_keys_debounce_repeat_module;

    localparam int T  = 10;
    localparam int PR = 4;
    localparam int RL = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int LAT_LO = 2 + (PR - 1) * T + 1 + 1;
    localparam int LAT_HI = 2 + PR * T + 1;

    logic       CLK;
    logic       RSTn;
    logic [3:0] keys_in;
    logic [3:0] key_pulse;
    logic [3:0] key_level;

    keys_debounce_repeat_module #(
        .TICK_CYCLES(T), .PRESS_MS(PR), .RELEASE_MS(RL),
        .REPEAT_DELAY_MS(RD), .REPEAT_RATE_MS(RR)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .keys_in(keys_in),
        .key_pulse(key_pulse), .key_level(key_level)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // Elapsed ticks are derived from edge timestamps: edge k is a tick edge when (k+1)%T==0.
    localparam int M_IDLE = 0, M_PRESS = 1, M_HELD = 2, M_REL = 3;
    logic [3:0] m_s1, m_s2, m_pulse, m_level;
    int         m_k;
    int         m_mode  [4];
    int         m_start [4];
    bit         m_first [4];

    function automatic int ticks_since(input int s, input int k);
        return (k + 1) / T - (s + 1) / T;
    endfunction

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF; m_pulse = '0; m_level = '0; m_k = 0;
        for (int i = 0; i < 4; i++) begin
            m_mode[i] = M_IDLE; m_start[i] = 0; m_first[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [3:0] keys);
        logic [3:0] p;
        int t;
        p = ~m_s2;
        m_pulse = '0;
        for (int i = 0; i < 4; i++) begin
            t = ticks_since(m_start[i], m_k);
            case (m_mode[i])
                M_IDLE:
                    if (p[i]) begin m_mode[i] = M_PRESS; m_start[i] = m_k; end
                M_PRESS:
                    if (!p[i]) m_mode[i] = M_IDLE;
                    else if (t == PR) begin
                        m_mode[i] = M_HELD; m_level[i] = 1'b1; m_pulse[i] = 1'b1;
                        m_start[i] = m_k; m_first[i] = 1'b1;
                    end
                M_HELD:
                    if (!p[i]) begin m_mode[i] = M_REL; m_start[i] = m_k; end
                    else if (RD != 0 && t == (m_first[i] ? RD : RR)) begin
                        m_pulse[i] = 1'b1; m_start[i] = m_k; m_first[i] = 1'b0;
                    end
                M_REL:
                    if (p[i]) begin m_mode[i] = M_HELD; m_start[i] = m_k; m_first[i] = 1'b1; end
                    else if (t == RL) begin m_mode[i] = M_IDLE; m_level[i] = 1'b0; end
                default: ;
            endcase
        end
        m_s2 = m_s1;
        m_s1 = keys;
        m_k++;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_cmp++;
        if (val < lo || val > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d..%0d at %0t", name, val, lo, hi, $time);
        end
    endtask

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic cycle(input logic [3:0] keys);
        keys_in = keys;
        @(posedge CLK);
        model_edge(keys);
        @(negedge CLK);
        check("pulse", {28'd0, key_pulse}, {28'd0, m_pulse});
        check("level", {28'd0, key_level}, {28'd0, m_level});
    endtask

    task automatic wait_pulse(input logic [3:0] keys, input int key, input int limit, output int lat);
        lat = -1;
        for (int c = 1; c <= limit; c++) begin
            cycle(keys);
            if (key_pulse[key] === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0]  keys;
        int          cycles;
        logic [15:0] exp_cnt;   // nibble i = strobes expected on key i
        logic [3:0]  exp_level;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int lat;
        int seen [4];
        int glitch_pulses;

        vecs[0]  = '{4'hF, 20,  16'h0000, 4'h0};
        vecs[1]  = '{4'hE, 60,  16'h0001, 4'h1};
        vecs[2]  = '{4'hF, 60,  16'h0000, 4'h0};
        vecs[3]  = '{4'hB, 60,  16'h0100, 4'h4};
        vecs[4]  = '{4'hF, 30,  16'h0000, 4'h4};
        vecs[5]  = '{4'hF, 20,  16'h0000, 4'h0};
        vecs[6]  = '{4'h7, 250, 16'h5000, 4'h8};
        vecs[7]  = '{4'hF, 50,  16'h0000, 4'h0};
        vecs[8]  = '{4'h6, 60,  16'h1001, 4'h9};
        vecs[9]  = '{4'hF, 50,  16'h0000, 4'h0};
        vecs[10] = '{4'hE, 30,  16'h0000, 4'h0};
        vecs[11] = '{4'hF, 50,  16'h0000, 4'h0};

        // Reset with every key pressed: outputs stay 0, then all four strobe together.
        RSTn = 1'b0;
        keys_in = 4'h0;
        model_reset();
        repeat (5) begin
            @(negedge CLK);
            check("rst_pulse", {28'd0, key_pulse}, 32'd0);
            check("rst_level", {28'd0, key_level}, 32'd0);
        end
        RSTn = 1'b1;
        model_reset();
        wait_pulse(4'h0, 0, 100, lat);
        check_range("rst_release_lat", lat, LAT_LO, LAT_HI);
        check("rst_release_all", {28'd0, key_pulse}, 32'hF);
        repeat (60) cycle(4'hF);

        // Bounce on key1 every 7 cycles, then a stable press.
        seen[1] = 0;
        for (int i = 0; i < 28; i++)
            repeat (7) begin
                cycle((i % 2 == 0) ? 4'hD : 4'hF);
                seen[1] += int'(key_pulse[1]);
            end
        check("bounce_pulses", seen[1], 0);
        wait_pulse(4'hD, 1, 100, lat);
        check_range("bounce_lat", lat, LAT_LO, LAT_HI);
        repeat (60) cycle(4'hF);

        // Release glitch on a held key0 restarts the repeat delay.
        wait_pulse(4'hE, 0, 100, lat);
        check_range("glitch_press_lat", lat, LAT_LO, LAT_HI);
        repeat (20) cycle(4'hE);
        glitch_pulses = 0;
        repeat (15) begin
            cycle(4'hF);
            glitch_pulses += int'(key_pulse[0]);
            check("glitch_level", {31'd0, key_level[0]}, 32'd1);
        end
        check("glitch_pulses", glitch_pulses, 0);
        wait_pulse(4'hE, 0, 150, lat);
        check_range("glitch_repeat_lat", lat, 3 + (RD - 1) * T + 1, 3 + RD * T);
        repeat (60) cycle(4'hF);

        // Segment table.
        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < 4; i++) seen[i] = 0;
            repeat (vecs[v].cycles) begin
                cycle(vecs[v].keys);
                for (int i = 0; i < 4; i++) seen[i] += int'(key_pulse[i]);
            end
            for (int i = 0; i < 4; i++)
                check($sformatf("vec%0d_cnt%0d", v, i), seen[i], {28'd0, vecs[v].exp_cnt[4*i +: 4]});
            check($sformatf("vec%0d_level", v), {28'd0, key_level}, {28'd0, vecs[v].exp_level});
        end

        // Random key activity against the model.
        for (int s = 0; s < 40; s++) begin
            logic [3:0] k;
            int len;
            k = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 70);
            repeat (len) cycle(k);
        end
        repeat (60) cycle(4'hF);

        // Simultaneous keys 0 and 3, then reset mid-hold.
        wait_pulse(4'h6, 0, 100, lat);
        check_range("simul_lat", lat, LAT_LO, LAT_HI);
        check("simul_pulse", {28'd0, key_pulse}, 32'h9);
        repeat (20) cycle(4'h6);
        check("simul_level", {28'd0, key_level}, 32'h9);
        #2;
        RSTn = 1'b0;
        #1;
        check("async_rst_pulse", {28'd0, key_pulse}, 32'd0);
        check("async_rst_level", {28'd0, key_level}, 32'd0);
        model_reset();
        repeat (3) begin
            @(negedge CLK);
            check("hold_rst_level", {28'd0, key_level}, 32'd0);
        end
        RSTn = 1'b1;
        model_reset();
        repeat (60) cycle(4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
